// File: rtl/feistel_cipher_iter_if.sv
// Block stream handshake for the iterative Feistel engine.
// The master side supplies input blocks and accepts results; the engine is the slave.
interface feistel_cipher_iter_if #(
   parameter int DATA_WIDTH = 256
);
   logic                  s_valid;
   logic                  s_ready;
   logic                  s_mode;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_mode;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      output s_valid, s_mode, s_data, m_ready,
      input  s_ready, m_valid, m_mode, m_data
   );

   modport slave (
      input  s_valid, s_mode, s_data, m_ready,
      output s_ready, m_valid, m_mode, m_data
   );
endinterface

// File: rtl/feistel_cipher_iter.sv
// Iterative Feistel engine: one round per clock, encrypt or decrypt per block,
// serially loaded S-box and writable round-key file.
//
// state | meaning
// IDLE  | waiting for a block; accepts only once the S-box table is complete
// RUN   | one Feistel round per edge, key index stepping up (enc) or down (dec)
// DONE  | result presented on m_*, held until the consumer takes it
module feistel_cipher_iter #(
   parameter int ROUNDS     = 5,
   parameter int DATA_WIDTH = 256,
   parameter int KEY_SIZE   = 128,
   parameter int SBOX_WIDTH = 8,
   localparam int KAW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sbox_valid,
   input  logic [SBOX_WIDTH-1:0] sbox_data,
   output logic                  sbox_ready,
   input  logic                  key_we,
   input  logic [KAW-1:0]        key_addr,
   input  logic [KEY_SIZE-1:0]   key_data,
   feistel_cipher_iter_if.slave  bus,
   output logic                  busy
);

   localparam int HW    = DATA_WIDTH / 2;
   localparam int LANES = HW / SBOX_WIDTH;
   localparam int DEPTH = 2 ** SBOX_WIDTH;
   localparam logic [KAW-1:0] LAST_IDX = KAW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;

   logic [SBOX_WIDTH-1:0] sbox_mem [DEPTH];
   logic [SBOX_WIDTH-1:0] sbox_ptr_q;
   logic                  sbox_ready_q;
   logic [KEY_SIZE-1:0]   key_mem [ROUNDS];

   logic [HW-1:0]         l_q, r_q;
   logic                  mode_q;
   logic [KAW-1:0]        idx_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic                  m_mode_q;

   logic                  accept;
   logic                  last_round;
   logic                  load_en;
   logic [HW-1:0]         f_in, f_x, f_sb, f_out, l_nxt, r_nxt;

   // ---------------- S-box table and key file ----------------
   assign load_en = sbox_valid & ~busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         sbox_ptr_q   <= '0;
         sbox_ready_q <= 1'b0;
      end else if (load_en) begin
         sbox_ptr_q <= sbox_ptr_q + 1'b1;
         if (sbox_ptr_q == '1) sbox_ready_q <= 1'b1;
      end
   end

   // Table and key contents survive reset; only the pointer and ready flag clear.
   always_ff @(posedge clk) begin
      if (load_en) sbox_mem[sbox_ptr_q] <= sbox_data;
   end

   always_ff @(posedge clk) begin
      if (key_we && !busy && (key_addr <= LAST_IDX)) key_mem[key_addr] <= key_data;
   end

   // ---------------- round function ----------------
   assign f_in = mode_q ? l_q : r_q;
   assign f_x  = f_in ^ key_mem[idx_q];

   always_comb begin
      f_sb = '0;
      for (int j = 0; j < LANES; j++) begin
         f_sb[j*SBOX_WIDTH +: SBOX_WIDTH] = sbox_mem[f_x[j*SBOX_WIDTH +: SBOX_WIDTH]];
      end
   end

   assign f_out = {f_sb[HW-SBOX_WIDTH-1:0], f_sb[HW-1 -: SBOX_WIDTH]};
   assign l_nxt = mode_q ? (r_q ^ f_out) : r_q;
   assign r_nxt = mode_q ? l_q : (l_q ^ f_out);

   assign last_round = mode_q ? (idx_q == '0) : (idx_q == LAST_IDX);

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      bus.s_ready = 1'b0;
      bus.m_valid = 1'b0;
      busy        = 1'b1;
      case (state_q)
         IDLE: begin
            busy        = 1'b0;
            bus.s_ready = sbox_ready_q;
            if (bus.s_valid && sbox_ready_q) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_round) state_d = DONE;
         end
         DONE: begin
            bus.m_valid = 1'b1;
            if (bus.m_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         l_q      <= '0;
         r_q      <= '0;
         mode_q   <= 1'b0;
         idx_q    <= '0;
         m_data_q <= '0;
         m_mode_q <= 1'b0;
      end else if (accept) begin
         {l_q, r_q} <= bus.s_data;
         mode_q     <= bus.s_mode;
         idx_q      <= bus.s_mode ? LAST_IDX : '0;
      end else if (state_q == RUN) begin
         l_q   <= l_nxt;
         r_q   <= r_nxt;
         idx_q <= mode_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
         if (last_round) begin
            m_data_q <= {l_nxt, r_nxt};
            m_mode_q <= mode_q;
         end
      end
   end

   assign sbox_ready = sbox_ready_q;
   assign bus.m_data = m_data_q;
   assign bus.m_mode = m_mode_q;

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Bench for feistel_cipher_iter: randomized blocks checked against a round-by-round
// reference model of the cipher, plus handshake, latency and reset scenarios.
module tb_feistel_cipher_iter;
   localparam int ROUNDS = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         reset;
   logic         sbox_valid, sbox_ready, key_we, busy;
   logic [7:0]   sbox_data;
   logic [2:0]   key_addr;
   logic [127:0] key_data;
   feistel_cipher_iter_if #(.DATA_WIDTH(256)) bus ();

   logic         sbox_valid1, sbox_ready1, key_we1, busy1;
   logic [7:0]   sbox_data1;
   logic [0:0]   key_addr1;
   logic [127:0] key_data1;
   feistel_cipher_iter_if #(.DATA_WIDTH(256)) bus1 ();

   feistel_cipher_iter #(.ROUNDS(ROUNDS), .DATA_WIDTH(256), .KEY_SIZE(128), .SBOX_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .sbox_valid(sbox_valid), .sbox_data(sbox_data),
      .sbox_ready(sbox_ready), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
      .bus(bus), .busy(busy));

   feistel_cipher_iter #(.ROUNDS(1), .DATA_WIDTH(256), .KEY_SIZE(128), .SBOX_WIDTH(8)) dut1 (
      .clk(clk), .reset(reset), .sbox_valid(sbox_valid1), .sbox_data(sbox_data1),
      .sbox_ready(sbox_ready1), .key_we(key_we1), .key_addr(key_addr1), .key_data(key_data1),
      .bus(bus1), .busy(busy1));

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: what the table and key file should hold.
   logic [7:0]   m_sbox [256];
   logic [127:0] m_key  [ROUNDS];
   int           tb_ptr = 0;

   function automatic logic [127:0] f_ref(input logic [127:0] x, input logic [127:0] k);
      logic [127:0] t, s;
      t = x ^ k;
      for (int j = 0; j < 16; j++) s[8*j +: 8] = m_sbox[t[8*j +: 8]];
      return {s[119:0], s[127:120]};
   endfunction

   function automatic logic [255:0] ref_cipher(input logic [255:0] blk, input bit dec, input int rounds);
      logic [127:0] l, r, t;
      l = blk[255:128];
      r = blk[127:0];
      if (!dec) begin
         for (int i = 0; i < rounds; i++) begin
            t = l ^ f_ref(r, m_key[i]); l = r; r = t;
         end
      end else begin
         for (int i = rounds - 1; i >= 0; i--) begin
            t = r ^ f_ref(l, m_key[i]); r = l; l = t;
         end
      end
      return {l, r};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 identity, 1 reversed, 2 random
   task automatic load_table(input int kind, input int count);
      logic [7:0] v;
      for (int i = 0; i < count; i++) begin
         v = (kind == 0) ? 8'(tb_ptr) : (kind == 1) ? 8'(255 - tb_ptr) : 8'($urandom);
         sbox_valid = 1'b1;
         sbox_data  = v;
         m_sbox[tb_ptr] = v;
         tb_ptr = (tb_ptr + 1) % 256;
         tick();
      end
      sbox_valid = 1'b0;
   endtask

   task automatic write_key(input int a, input logic [127:0] k);
      key_we   = 1'b1;
      key_addr = a[2:0];
      key_data = k;
      if (a < ROUNDS) m_key[a] = k;
      tick();
      key_we = 1'b0;
   endtask

   task automatic send(input logic [255:0] d, input bit md, output int acc_cyc);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_mode  = md;
      acc_cyc     = -1;
      for (int i = 0; i < 100; i++) begin
         if (bus.s_ready === 1'b1) begin
            tick();
            acc_cyc = cyc;
            break;
         end
         tick();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic recv(input int hold, output logic [255:0] d, output logic md, output int lat);
      lat = -1;
      d   = '0;
      md  = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (bus.m_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat > 0) begin
         d  = bus.m_data;
         md = bus.m_mode;
         repeat (hold) tick();
         bus.m_ready = 1'b1;
         tick();
         bus.m_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      n_cmp++; if (sbox_ready !== 1'b0) begin n_err++; $display("FAIL reset_sbox_ready: got %b want 0", sbox_ready); end
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
      n_cmp++; if (bus.m_data !== 256'h0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
      n_cmp++; if (bus.m_mode !== 1'b0) begin n_err++; $display("FAIL reset_m_mode: got %b want 0", bus.m_mode); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (sbox_ready1 !== 1'b0) begin n_err++; $display("FAIL reset_sbox_ready_r1: got %b want 0", sbox_ready1); end
   endtask

   task automatic test_sbox_partial();
      load_table(0, 255);
      n_cmp++; if (sbox_ready !== 1'b0) begin n_err++; $display("FAIL partial_sbox_ready: got %b want 0", sbox_ready); end
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL partial_s_ready: got %b want 0", bus.s_ready); end
      bus.s_valid = 1'b1;
      bus.s_data  = rand256();
      tick();
      bus.s_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL partial_not_accepted: busy got %b want 0", busy); end
      load_table(0, 1);
      n_cmp++; if (sbox_ready !== 1'b1) begin n_err++; $display("FAIL full_sbox_ready: got %b want 1", sbox_ready); end
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL full_s_ready: got %b want 1", bus.s_ready); end
   endtask

   task automatic test_zero();
      logic [255:0] d;
      logic         md;
      int           acc, lat;
      for (int i = 0; i < ROUNDS; i++) write_key(i, 128'h0);
      send(256'h0, 1'b0, acc);
      recv(0, d, md, lat);
      n_cmp++; if (lat !== ROUNDS) begin n_err++; $display("FAIL zero_latency: got %0d want %0d", lat, ROUNDS); end
      n_cmp++; if (d !== 256'h0) begin n_err++; $display("FAIL zero_data: got %h want 0", d); end
      n_cmp++; if (md !== 1'b0) begin n_err++; $display("FAIL zero_mode: got %b want 0", md); end
   endtask

   // Single-round instance; m_key[0] is zero here, matching the key written below.
   task automatic test_rounds1();
      logic [255:0] pt, got;
      int lat;
      pt = {{16{8'hA5}}, 128'h0};
      sbox_valid1 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         sbox_data1 = 8'(i);
         tick();
      end
      sbox_valid1 = 1'b0;
      key_we1 = 1'b1; key_addr1 = 1'b0; key_data1 = 128'h0;
      tick();
      key_we1 = 1'b0;
      n_cmp++; if (sbox_ready1 !== 1'b1) begin n_err++; $display("FAIL r1_sbox_ready: got %b want 1", sbox_ready1); end
      bus1.s_valid = 1'b1; bus1.s_data = pt; bus1.s_mode = 1'b0;
      for (int i = 0; i < 20 && bus1.s_ready !== 1'b1; i++) tick();
      tick();
      bus1.s_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus1.m_valid === 1'b1) begin lat = i; break; end
      end
      got = bus1.m_data;
      bus1.m_ready = 1'b1; tick(); bus1.m_ready = 1'b0;
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL r1_latency: got %0d want 1", lat); end
      n_cmp++; if (got !== {128'h0, {16{8'hA5}}}) begin n_err++; $display("FAIL r1_data: got %h want %h", got, {128'h0, {16{8'hA5}}}); end
      n_cmp++; if (got !== ref_cipher(pt, 1'b0, 1)) begin n_err++; $display("FAIL r1_model: got %h want %h", got, ref_cipher(pt, 1'b0, 1)); end
   endtask

   task automatic test_back_to_back();
      logic [255:0] pts [3];
      logic [255:0] cts [3];
      logic [255:0] d;
      logic [127:0] k;
      logic         md;
      int           acc, prev, lat;
      load_table(1, 256);
      for (int i = 0; i < ROUNDS; i++) begin
         for (int b = 0; b < 16; b++) k[8*(15-b) +: 8] = 8'(16*i + b);
         write_key(i, k);
      end
      pts[0] = {128'h112233445566778899AABBCCDDEEFF00, 128'h00112233445566778899AABBCCDDEEFF};
      pts[1] = rand256();
      pts[2] = rand256();
      prev = 0;
      for (int j = 0; j < 3; j++) begin
         send(pts[j], 1'b0, acc);
         if (j > 0) begin
            n_cmp++; if (acc - prev !== ROUNDS + 2) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d want %0d", j, acc - prev, ROUNDS + 2); end
         end
         prev = acc;
         recv(0, d, md, lat);
         cts[j] = d;
         n_cmp++; if (d !== ref_cipher(pts[j], 1'b0, ROUNDS)) begin n_err++; $display("FAIL b2b_enc%0d: got %h want %h", j, d, ref_cipher(pts[j], 1'b0, ROUNDS)); end
         n_cmp++; if (lat !== ROUNDS) begin n_err++; $display("FAIL b2b_latency%0d: got %0d want %0d", j, lat, ROUNDS); end
      end
      for (int j = 0; j < 3; j++) begin
         send(cts[j], 1'b1, acc);
         recv(0, d, md, lat);
         n_cmp++; if (d !== pts[j]) begin n_err++; $display("FAIL b2b_dec%0d: got %h want %h", j, d, pts[j]); end
         n_cmp++; if (md !== 1'b1) begin n_err++; $display("FAIL b2b_dec_mode%0d: got %b want 1", j, md); end
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] a, b, hold, d, exp_a;
      logic         ma, mb, md;
      int           acc, lat;
      a = rand256(); b = rand256();
      ma = 1'($urandom); mb = 1'($urandom);
      exp_a = ref_cipher(a, ma, ROUNDS);
      send(a, ma, acc);
      for (int i = 0; i < 20 && bus.m_valid !== 1'b1; i++) tick();
      hold = bus.m_data;
      n_cmp++; if (hold !== exp_a) begin n_err++; $display("FAIL bp_data: got %h want %h", hold, exp_a); end
      bus.s_valid = 1'b1; bus.s_data = b; bus.s_mode = mb;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if ({bus.m_valid, bus.s_ready, bus.m_mode, bus.m_data} !== {1'b1, 1'b0, ma, exp_a}) begin
            n_err++;
            $display("FAIL bp_hold%0d: got v=%b rdy=%b mode=%b data=%h want v=1 rdy=0 mode=%b data=%h",
                     i, bus.m_valid, bus.s_ready, bus.m_mode, bus.m_data, ma, exp_a);
         end
      end
      bus.m_ready = 1'b1; tick(); bus.m_ready = 1'b0;
      send(b, mb, acc);
      recv(0, d, md, lat);
      n_cmp++; if (d !== ref_cipher(b, mb, ROUNDS)) begin n_err++; $display("FAIL bp_next: got %h want %h", d, ref_cipher(b, mb, ROUNDS)); end
      n_cmp++; if (md !== mb) begin n_err++; $display("FAIL bp_next_mode: got %b want %b", md, mb); end
   endtask

   task automatic test_busy_ignore();
      logic [255:0] c, d;
      logic         md;
      int           acc, lat;
      write_key(6, rand256()[127:0]);
      c = rand256();
      send(c, 1'b0, acc);
      tick();
      sbox_valid = 1'b1; sbox_data = 8'h3C;
      key_we = 1'b1; key_addr = 3'd0; key_data = ~m_key[0];
      repeat (2) tick();
      sbox_valid = 1'b0; key_we = 1'b0;
      recv(0, d, md, lat);
      n_cmp++; if (d !== ref_cipher(c, 1'b0, ROUNDS)) begin n_err++; $display("FAIL busy_ignore: got %h want %h", d, ref_cipher(c, 1'b0, ROUNDS)); end
      c = rand256();
      send(c, 1'b1, acc);
      recv(0, d, md, lat);
      n_cmp++; if (d !== ref_cipher(c, 1'b1, ROUNDS)) begin n_err++; $display("FAIL busy_after: got %h want %h", d, ref_cipher(c, 1'b1, ROUNDS)); end
   endtask

   task automatic test_random();
      logic [255:0] p, d;
      logic         m, md;
      int           acc, lat;
      load_table(2, 256);
      for (int i = 0; i < ROUNDS; i++) write_key(i, rand256()[127:0]);
      for (int j = 0; j < 8; j++) begin
         p = rand256();
         m = 1'($urandom);
         send(p, m, acc);
         recv(int'($urandom_range(3, 0)), d, md, lat);
         n_cmp++; if (d !== ref_cipher(p, m, ROUNDS)) begin n_err++; $display("FAIL rand%0d_data: got %h want %h", j, d, ref_cipher(p, m, ROUNDS)); end
         n_cmp++; if (md !== m) begin n_err++; $display("FAIL rand%0d_mode: got %b want %b", j, md, m); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [255:0] p, d;
      logic         md;
      int           acc, lat;
      send(rand256(), 1'b0, acc);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid: got %b want 0", bus.m_valid); end
      n_cmp++; if (sbox_ready !== 1'b0) begin n_err++; $display("FAIL midrst_sbox_ready: got %b want 0", sbox_ready); end
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL midrst_s_ready: got %b want 0", bus.s_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
      tb_ptr = 0;
      bus.s_valid = 1'b1; bus.s_data = rand256();
      repeat (3) tick();
      bus.s_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_no_accept: busy got %b want 0", busy); end
      load_table(0, 256);
      p = rand256();
      send(p, 1'b0, acc);
      recv(0, d, md, lat);
      n_cmp++; if (d !== ref_cipher(p, 1'b0, ROUNDS)) begin n_err++; $display("FAIL midrst_reload: got %h want %h", d, ref_cipher(p, 1'b0, ROUNDS)); end
   endtask

   initial begin
      reset = 1'b1;
      sbox_valid = 1'b0; sbox_data = '0; key_we = 1'b0; key_addr = '0; key_data = '0;
      bus.s_valid = 1'b0; bus.s_mode = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      sbox_valid1 = 1'b0; sbox_data1 = '0; key_we1 = 1'b0; key_addr1 = '0; key_data1 = '0;
      bus1.s_valid = 1'b0; bus1.s_mode = 1'b0; bus1.s_data = '0; bus1.m_ready = 1'b0;
      test_reset();
      test_sbox_partial();
      test_zero();
      test_rounds1();
      test_back_to_back();
      test_backpressure();
      test_busy_ignore();
      test_random();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "time limit");
   end
endmodule
